// File: rtl/btn_pkg.sv
// btn_pkg: shared state encoding and debounce length defaults for the button conditioner
package btn_pkg;

    typedef enum logic [1:0] {IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW} btn_state_t;

    localparam int DEBOUNCE_SIM   = 10;
    localparam int DEBOUNCE_BOARD = 1_000_000;

endpackage

// File: rtl/btn_debounce_ch.sv
// btn_debounce_ch: one button channel (2-flop synchronizer, debounce FSM, saturating counter,
// optional auto-repeat enabled by BTN_AUTO_REPEAT_EN)
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_SIM,
    parameter int REPEAT_DELAY    = 20,
    parameter int REPEAT_PERIOD   = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);

    localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]  CNT_MAX  = CW'(DEBOUNCE_CYCLES);

    logic          s1_q, s2_q;
    btn_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          rpt_fire;

    // two-flop synchronizer; the FSM only ever looks at s2_q
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= btn_in;
            s2_q <= s1_q;
        end
    end

`ifdef BTN_AUTO_REPEAT_EN
    localparam int             RW         = $clog2(REPEAT_DELAY + 1);
    localparam logic [RW-1:0]  RPT_LAST   = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0]  RPT_RELOAD = RW'(REPEAT_DELAY - REPEAT_PERIOD);

    logic [RW-1:0] rpt_q, rpt_d;

    // hold timer: counts only while held in IDLE_HIGH, reloads after each repeat pulse
    always_comb begin
        rpt_d    = '0;
        rpt_fire = 1'b0;
        if (state_q == IDLE_HIGH && s2_q) begin
            rpt_fire = (rpt_q == RPT_LAST);
            rpt_d    = rpt_fire ? RPT_RELOAD : rpt_q + 1'b1;
        end
    end

    // repeat counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rpt_q <= '0;
        else        rpt_q <= rpt_d;
    end
`else
    assign rpt_fire = 1'b0;
`endif

    // debounce FSM: a change is accepted after DEBOUNCE_CYCLES consecutive stable samples
    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        level_d   = level_q;
        press_d   = rpt_fire;
        release_d = 1'b0;
        case (state_q)
            IDLE_LOW: begin
                if (s2_q) begin
                    state_d = WAIT_HIGH;
                    cnt_d   = CW'(1);
                end
            end
            WAIT_HIGH: begin
                if (!s2_q) begin
                    state_d = IDLE_LOW;
                end else if (cnt_q >= CNT_LAST) begin
                    state_d = IDLE_HIGH;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                end
            end
            IDLE_HIGH: begin
                if (!s2_q) begin
                    state_d = WAIT_LOW;
                    cnt_d   = CW'(1);
                end
            end
            WAIT_LOW: begin
                if (s2_q) begin
                    state_d = IDLE_HIGH;
                end else if (cnt_q >= CNT_LAST) begin
                    state_d   = IDLE_LOW;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE_LOW;
        endcase
    end

    // FSM state, counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE_LOW;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;

endmodule

// File: rtl/btn_debounce.sv
// btn_debounce: N_BTN independent debounced button channels with level and press/release pulses
// (auto-repeat on held buttons when BTN_AUTO_REPEAT_EN is defined)
module btn_debounce
    import btn_pkg::*;
#(
    parameter int N_BTN           = 5,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_SIM,
    parameter int REPEAT_DELAY    = 20,
    parameter int REPEAT_PERIOD   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release
);

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .btn_in     (btn_in[g]),
            .btn_level  (btn_level[g]),
            .btn_press  (btn_press[g]),
            .btn_release(btn_release[g])
        );
    end

endmodule

// File: tb/tb_btn_debounce.sv
// tb_btn_debounce: directed self-checking bench for btn_debounce (DEBOUNCE_CYCLES=10, 5 channels)
module tb_btn_debounce;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] btn_in;
    logic [4:0] btn_level, btn_press, btn_release;
    int         errors = 0;
    int         checks = 0;

    btn_debounce #(
        .N_BTN(5), .DEBOUNCE_CYCLES(10), .REPEAT_DELAY(20), .REPEAT_PERIOD(5)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_in(btn_in),
        .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release)
    );

    always #5 clk = ~clk;

    // advance n rising edges, then settle 1 time unit past the edge
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    logic [4:0] exp_p;

    initial begin
        // reset held with all buttons pressed: outputs stay 0
        rst_n  = 1'b0;
        btn_in = 5'b11111;
        for (int i = 0; i < 20; i++) begin
            step(1);
            chk("rst_level", btn_level, 5'b0);
            chk("rst_press", btn_press, 5'b0);
            chk("rst_release", btn_release, 5'b0);
        end
        // held through reset release: accepted 12 edges later
        rst_n = 1'b1;
        step(11);
        chk("hold_lvl_pre", btn_level, 5'b00000);
        chk("hold_prs_pre", btn_press, 5'b00000);
        step(1);
        chk("hold_lvl", btn_level, 5'b11111);
        chk("hold_prs", btn_press, 5'b11111);
        step(1);
        chk("hold_prs_end", btn_press, 5'b00000);
        chk("hold_lvl_end", btn_level, 5'b11111);

        // release everything
        btn_in = 5'b00000;
        step(11);
        chk("rel_all_pre", btn_release, 5'b00000);
        chk("rel_all_lvl_pre", btn_level, 5'b11111);
        step(1);
        chk("rel_all", btn_release, 5'b11111);
        chk("rel_all_lvl", btn_level, 5'b00000);
        chk("rel_all_noprs", btn_press, 5'b00000);
        step(1);
        chk("rel_all_end", btn_release, 5'b00000);

        // clean press/release on channel 0
        step(3);
        btn_in = 5'b00001;
        step(11);
        chk("c0_prs_pre", btn_press, 5'b00000);
        step(1);
        chk("c0_prs", btn_press, 5'b00001);
        chk("c0_lvl", btn_level, 5'b00001);
        step(1);
        chk("c0_prs_end", btn_press, 5'b00000);
        step(5);
        btn_in = 5'b00000;
        step(11);
        chk("c0_rel_pre", btn_release, 5'b00000);
        step(1);
        chk("c0_rel", btn_release, 5'b00001);
        chk("c0_rel_lvl", btn_level, 5'b00000);
        step(1);
        chk("c0_rel_end", btn_release, 5'b00000);

        // bounce: 5 high, 3 low, then steady high -> one press at t'+12
        step(3);
        btn_in = 5'b00001;
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("bnc_hi", btn_press, 5'b0);
        end
        btn_in = 5'b00000;
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("bnc_lo", btn_press, 5'b0);
        end
        btn_in = 5'b00001;
        for (int i = 1; i <= 14; i++) begin
            step(1);
            chk("bnc_prs", btn_press, (i == 12) ? 5'b00001 : 5'b00000);
            chk("bnc_lvl", btn_level, (i >= 12) ? 5'b00001 : 5'b00000);
        end
        btn_in = 5'b00000;
        step(12);
        chk("bnc_rel", btn_release, 5'b00001);

        // 9-cycle glitch on channel 2: nothing happens
        step(3);
        btn_in = 5'b00100;
        step(9);
        btn_in = 5'b00000;
        for (int i = 0; i < 16; i++) begin
            chk("gl_lvl", btn_level, 5'b0);
            chk("gl_prs", btn_press, 5'b0);
            chk("gl_rel", btn_release, 5'b0);
            step(1);
        end

        // mid-count reset while channels 0,1,3 are counting
        btn_in = 5'b01011;
        step(6);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_lvl", btn_level, 5'b0);
        chk("mid_rst_prs", btn_press, 5'b0);
        btn_in = 5'b01010;
        for (int i = 0; i < 8; i++) begin
            step(1);
            chk("mid_rst_prs_hold", btn_press, 5'b0);
        end
        // channels 1 and 3 held through reset release: coincident pulses
        rst_n = 1'b1;
        step(11);
        chk("c13_pre", btn_press, 5'b00000);
        step(1);
        chk("c13_prs", btn_press, 5'b01010);
        chk("c13_lvl", btn_level, 5'b01010);
        btn_in = 5'b00000;
        step(12);
        chk("c13_rel", btn_release, 5'b01010);
        chk("c13_rel_noprs", btn_press, 5'b00000);

        // long hold on channel 4 (repeats only in the auto-repeat build)
        step(3);
        btn_in = 5'b10000;
        for (int i = 1; i <= 43; i++) begin
            step(1);
`ifdef BTN_AUTO_REPEAT_EN
            exp_p = (i == 12 || i == 32 || i == 37 || i == 42) ? 5'b10000 : 5'b00000;
`else
            exp_p = (i == 12) ? 5'b10000 : 5'b00000;
`endif
            chk("c4_hold_prs", btn_press, exp_p);
            chk("c4_hold_rel", btn_release, 5'b00000);
        end
        btn_in = 5'b00000;
        for (int i = 1; i <= 16; i++) begin
            step(1);
            chk("c4_rel_prs", btn_press, 5'b00000);
            chk("c4_rel", btn_release, (i == 12) ? 5'b10000 : 5'b00000);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
